opponent_state_tracker: RTL and testbench

- Sits directly downstream of the Ethernet receive block; consumes its 44-bit frame output (axiov/axiod).
- Validates each frame, extracts the opponent fields and holds them as registered state for the track, racer and forward views.
- Tracks link health (acquire / linked / timeout) and generates a one-cycle opponent-reset request.
- Runs in the Ethernet reference clock domain.

---
 rtl/opponent_state_tracker.sv | 156 +++++++++++++++
 tb/tb_opponent_state_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/opponent_state_tracker.sv
// Validates received opponent frames, holds their fields and tracks link health (down/acquire/linked).
// One cycle from axiiv to all outputs; no backpressure, so every cycle can carry a frame.
module opponent_state_tracker #(
  parameter int TRACK_MAX      = 511,
  parameter int DIR_MAX        = 359,
  parameter int ACQUIRE_COUNT  = 3,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiiv,
  input  logic [43:0] axiid,
  output logic [10:0] opponent_x,
  output logic [10:0] opponent_y,
  output logic [8:0]  opponent_dir,
  output logic [2:0]  opponent_game,
  output logic        opponent_valid,
  output logic        link_up,
  output logic        update_pulse,
  output logic        reset_req,
  output logic [7:0]  drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [10:0]   TRACK_LIM = 11'(TRACK_MAX);
  localparam logic [8:0]    DIR_LIM   = 9'(DIR_MAX);
  localparam logic [3:0]    ACQ_LIM   = 4'(ACQUIRE_COUNT);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LINK_DOWN, ACQUIRE, LINKED} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    acq_cnt;
  logic [34:0]   last_frame;

  logic [10:0] f_x;
  logic [10:0] f_y;
  logic [8:0]  f_dir;
  logic [2:0]  f_game;
  logic        f_rst;
  logic [34:0] frame_key;
  logic        is_null;
  logic        is_bad;
  logic        accept;
  logic        reject;
  logic        dup;
  logic        timed_out;
  logic [3:0]  acq_next;
  logic        unused_bits;

  assign f_x       = axiid[43:33];
  assign f_y       = axiid[31:21];
  assign f_dir     = axiid[19:11];
  assign f_game    = axiid[7:5];
  assign f_rst     = axiid[3];
  assign frame_key = {f_x, f_y, f_dir, f_game, f_rst};
  assign unused_bits = ^{axiid[32], axiid[20], axiid[10:8], axiid[4], axiid[2:0]};

  assign is_null   = (axiid == 44'd0);
  assign is_bad    = (f_x > TRACK_LIM) || (f_y > TRACK_LIM) || (f_dir > DIR_LIM);
  assign accept    = axiiv && !is_null && !is_bad;
  assign reject    = axiiv && !is_null && is_bad;
  assign dup       = (frame_key == last_frame);
  assign timed_out = (timer == TO_LIM);
  assign acq_next  = acq_cnt + 4'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= LINK_DOWN;
      timer          <= '0;
      acq_cnt        <= '0;
      last_frame     <= '0;
      opponent_x     <= '0;
      opponent_y     <= '0;
      opponent_dir   <= '0;
      opponent_game  <= '0;
      opponent_valid <= 1'b0;
      link_up        <= 1'b0;
      update_pulse   <= 1'b0;
      reset_req      <= 1'b0;
      drop_count     <= '0;
    end else begin
      update_pulse <= 1'b0;
      reset_req    <= 1'b0;

      if (reject && drop_count != 8'hff)
        drop_count <= drop_count + 8'd1;

      // Field loading and reset requests do not depend on link state.
      if (accept) begin
        opponent_x    <= f_x;
        opponent_y    <= f_y;
        opponent_dir  <= f_dir;
        opponent_game <= f_game;
        last_frame    <= frame_key;
        reset_req     <= f_rst;
        timer         <= '0;
      end

      case (state)
        LINK_DOWN: begin
          timer <= '0;
          if (accept) begin
            acq_cnt <= 4'd1;
            if (ACQ_LIM <= 4'd1) begin
              state          <= LINKED;
              opponent_valid <= 1'b1;
              link_up        <= 1'b1;
              update_pulse   <= 1'b1;
            end else begin
              state <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (accept) begin
            acq_cnt <= acq_next;
            // Entering LINKED always announces the data, duplicate or not.
            if (acq_next >= ACQ_LIM) begin
              state          <= LINKED;
              opponent_valid <= 1'b1;
              link_up        <= 1'b1;
              update_pulse   <= 1'b1;
            end
          end else if (timed_out) begin
            state   <= LINK_DOWN;
            acq_cnt <= '0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LINKED: begin
          if (accept) begin
            if (!dup)
              update_pulse <= 1'b1;
          end else if (timed_out) begin
            state          <= LINK_DOWN;
            opponent_valid <= 1'b0;
            link_up        <= 1'b0;
            acq_cnt        <= '0;
            timer          <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= LINK_DOWN;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opponent_state_tracker.sv
// Directed bench for opponent_state_tracker with TIMEOUT_CYCLES=100, ACQUIRE_COUNT=3.
module tb_opponent_state_tracker;

  logic        clk_in;
  logic        rst_in;
  logic        axiiv;
  logic [43:0] axiid;
  logic [10:0] opponent_x;
  logic [10:0] opponent_y;
  logic [8:0]  opponent_dir;
  logic [2:0]  opponent_game;
  logic        opponent_valid;
  logic        link_up;
  logic        update_pulse;
  logic        reset_req;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  opponent_state_tracker #(
    .TRACK_MAX(511), .DIR_MAX(359), .ACQUIRE_COUNT(3), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .axiiv(axiiv), .axiid(axiid),
    .opponent_x(opponent_x), .opponent_y(opponent_y), .opponent_dir(opponent_dir),
    .opponent_game(opponent_game), .opponent_valid(opponent_valid), .link_up(link_up),
    .update_pulse(update_pulse), .reset_req(reset_req), .drop_count(drop_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int game, input bit rst);
    logic [43:0] f;
    f = '0;
    f[43:33] = 11'(x);
    f[31:21] = 11'(y);
    f[19:11] = 9'(dir);
    f[7:5]   = 3'(game);
    f[3]     = rst;
    return f;
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge that samples the frame.
  task automatic send(input logic [43:0] f);
    axiiv = 1'b1;
    axiid = f;
    @(posedge clk_in); #1;
    axiiv = 1'b0;
    axiid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  logic [43:0] fa, fb, fr;

  initial begin
    fa = mk(191, 191, 270, 1, 1'b0);
    fb = mk(320, 320, 270, 1, 1'b0);
    fr = mk(191, 191, 270, 1, 1'b1);
    rst_in = 1'b1;
    axiiv  = 1'b0;
    axiid  = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_x", opponent_x, 0);
    check("rst_valid", opponent_valid, 0);
    check("rst_link", link_up, 0);
    check("rst_drop", drop_count, 0);
    rst_in = 1'b0;
    idle(1);

    // Acquisition: three frames, 10 cycles apart
    send(fa);
    check("acq1_valid", opponent_valid, 0);
    idle(10);
    send(fa);
    check("acq2_valid", opponent_valid, 0);
    idle(10);
    send(fa);
    check("acq3_valid", opponent_valid, 1);
    check("acq3_link", link_up, 1);
    check("acq3_pulse", update_pulse, 1);
    check("acq3_x", opponent_x, 191);
    check("acq3_y", opponent_y, 191);
    check("acq3_dir", opponent_dir, 270);
    check("acq3_game", opponent_game, 1);
    idle(1);
    check("acq3_pulse_once", update_pulse, 0);

    // Data change while linked, then a duplicate
    send(fb);
    check("upd_pulse", update_pulse, 1);
    check("upd_x", opponent_x, 320);
    check("upd_y", opponent_y, 320);
    idle(50);
    send(fb);
    check("dup_pulse", update_pulse, 0);
    idle(99);
    check("dup_refresh_link", link_up, 1);

    // Timeout: timer now 99
    idle(1);
    check("to_edge_link", link_up, 1);
    idle(1);
    check("to_link", link_up, 0);
    check("to_valid", opponent_valid, 0);
    check("to_hold_x", opponent_x, 320);
    check("to_hold_y", opponent_y, 320);
    send(fa);
    check("reacq_valid", opponent_valid, 0);
    check("reacq_pulse", update_pulse, 0);
    check("reacq_x", opponent_x, 191);

    // Rejects and null frames
    send(mk(600, 100, 10, 2, 1'b0));
    check("drop_x", drop_count, 1);
    check("drop_x_hold", opponent_x, 191);
    send(mk(100, 100, 400, 2, 1'b0));
    check("drop_dir", drop_count, 2);
    check("drop_dir_hold", opponent_dir, 270);
    send(44'd0);
    check("drop_null", drop_count, 2);
    for (int i = 0; i < 300; i++) send(mk(512, 0, 0, 0, 1'b0));
    check("drop_sat", drop_count, 255);
    check("drop_sat_x", opponent_x, 191);

    // Back-to-back acquisition from LINK_DOWN
    send(fa);
    send(fa);
    check("b2b_valid2", opponent_valid, 0);
    send(fa);
    check("b2b_valid3", opponent_valid, 1);
    check("b2b_pulse", update_pulse, 1);

    // Reset-request frame arriving as timer hits 100
    idle(100);
    send(fr);
    check("rreq_pulse", reset_req, 1);
    check("rreq_link", link_up, 1);
    idle(1);
    check("rreq_once", reset_req, 0);
    check("rreq_link_after", link_up, 1);

    // Asynchronous reset mid-ACQUIRE with counter at 2
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    idle(1);
    send(fa);
    send(fa);
    check("ar_pre_valid", opponent_valid, 0);
    #2 rst_in = 1'b1;
    #1;
    check("ar_x", opponent_x, 0);
    check("ar_dir", opponent_dir, 0);
    check("ar_drop", drop_count, 0);
    check("ar_valid", opponent_valid, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle(1);
    send(fa);
    send(fa);
    check("ar_acq2_valid", opponent_valid, 0);
    send(fa);
    check("ar_acq3_valid", opponent_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
